key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 140 ++++++++++++++
 tb/tb_key_conditioner.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchroniser, debouncer and single-press FSM for four active-low buttons.
// Define KEYCOND_STUCK_DETECT_EN to add the stuckKey output and its hold counter.
module key_conditioner #(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int DEBOUNCE_MS = 20
`ifdef KEYCOND_STUCK_DETECT_EN
    ,
    parameter int STUCK_MS    = 5000
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keyRaw,
    output logic [3:0] key,
    output logic       busy
`ifdef KEYCOND_STUCK_DETECT_EN
    ,
    output logic       stuckKey
`endif
);

    localparam int DEBOUNCE_CYCLES = (CLOCK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESSED = 2'd1;
    localparam logic [1:0] INVALID = 2'd2;

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    db_q, db_d;
    logic [3:0]    sample;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [1:0]    state_q, state_d;
    logic [3:0]    key_q, key_d;
    logic          busy_q, busy_d;

    // Debounce: any cycle of agreement restarts the stability window.
    always_comb begin
        sync1_d = keyRaw;
        sync2_d = sync1_q;
        sample  = ~sync2_q;
        db_d    = db_q;
        for (int n = 0; n < 4; n++) begin
            cnt_d[n] = '0;
            if (sample[n] != db_q[n]) begin
                if (cnt_q[n] == DB_LAST) begin
                    db_d[n] = sample[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = 4'b0000;
        unique case (state_q)
            IDLE: begin
                if (db_q != 4'b0000) begin
                    if ($onehot(db_q)) begin
                        key_d   = db_q;
                        state_d = PRESSED;
                    end else begin
                        state_d = INVALID;
                    end
                end
            end
            PRESSED, INVALID: begin
                if (db_q == 4'b0000) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
            db_q    <= 4'b0000;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= '0;
            end
            state_q <= IDLE;
            key_q   <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            state_q <= state_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
        end
    end

    assign key  = key_q;
    assign busy = busy_q;

`ifdef KEYCOND_STUCK_DETECT_EN
    localparam int STUCK_CYCLES = (CLOCK_FREQ / 1000) * STUCK_MS;
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] ST_LAST = SW'(STUCK_CYCLES - 1);

    logic [SW-1:0] hold_q, hold_d;
    logic          stuck_q, stuck_d;

    // Hold count saturates so stuckKey cannot drop while still held.
    always_comb begin
        hold_d  = '0;
        stuck_d = 1'b0;
        if (state_q != IDLE) begin
            hold_d  = (hold_q == ST_LAST) ? hold_q : hold_q + SW'(1);
            stuck_d = stuck_q | (hold_q == ST_LAST);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q  <= '0;
            stuck_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            stuck_q <= stuck_d;
        end
    end

    assign stuckKey = stuck_q;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed and random button stimulus checked against a
// history-based reference model of sync, debounce and press FSM.
module tb_key_conditioner;

    localparam int CF  = 50000;
    localparam int DMS = 1;
    localparam int DC  = 50;
    localparam int ST  = 200;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic [3:0] keyRaw = 4'hF;
    logic [3:0] key;
    logic       busy;
`ifdef KEYCOND_STUCK_DETECT_EN
    logic       stuck_key;
`endif

    always #5 clock = ~clock;

`ifdef KEYCOND_STUCK_DETECT_EN
    key_conditioner #(
        .CLOCK_FREQ (CF),
        .DEBOUNCE_MS(DMS),
        .STUCK_MS   (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .keyRaw  (keyRaw),
        .key     (key),
        .busy    (busy),
        .stuckKey(stuck_key)
    );
`else
    key_conditioner #(
        .CLOCK_FREQ (CF),
        .DEBOUNCE_MS(DMS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .keyRaw(keyRaw),
        .key   (key),
        .busy  (busy)
    );
`endif

    int         checks   = 0;
    int         errors   = 0;
    int         edge_cnt = 0;
    int         pulses   = 0;
    int         last_pe  = -1;
    logic [3:0] last_pv  = 4'h0;
    logic [3:0] prev_key = 4'h0;

    // Reference model: pressed-sample history, run lengths, press mode.
    logic [3:0] pipe [$];
    logic [3:0] m_db;
    logic [3:0] s_prev;
    int         srun [4];
    int         mode;
    logic [3:0] m_key;
    logic       m_busy;
    int         held;
    logic       m_stuck;
`ifdef KEYCOND_STUCK_DETECT_EN
    int         rise_e   = -1;
    int         fall_e   = -1;
    logic       prev_stk = 1'b0;
`endif

    function automatic void model_reset();
        pipe.delete();
        pipe.push_back(4'h0);
        pipe.push_back(4'h0);
        m_db    = 4'h0;
        s_prev  = 4'h0;
        for (int n = 0; n < 4; n++) srun[n] = 0;
        mode    = 0;
        m_key   = 4'h0;
        m_busy  = 1'b0;
        held    = 0;
        m_stuck = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [3:0] s_now;
        logic [3:0] old_db;
        if (reset) begin
            model_reset();
            return;
        end
        s_now  = pipe[0];
        old_db = m_db;
        for (int n = 0; n < 4; n++) begin
            if (s_now[n] == s_prev[n]) srun[n]++;
            else srun[n] = 1;
            if (s_now[n] != m_db[n] && srun[n] >= DC) m_db[n] = s_now[n];
        end
        if (mode == 0) begin
            held    = 0;
            m_stuck = 1'b0;
        end else begin
            if (held == ST - 1) m_stuck = 1'b1;
            held++;
        end
        m_key = 4'h0;
        if (mode == 0) begin
            if (old_db != 4'h0) begin
                if ($countones(old_db) == 1) begin
                    m_key = old_db;
                    mode  = 1;
                end else begin
                    mode = 2;
                end
            end
        end else if (old_db == 4'h0) begin
            mode = 0;
        end
        m_busy = (mode != 0);
        s_prev = s_now;
        void'(pipe.pop_front());
        pipe.push_back(~keyRaw);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        edge_cnt++;
        chk("key", key, m_key);
        chk("busy", busy, m_busy);
        chk("key_onehot", ($countones(key) <= 1), 1);
        chk("key_gap", (key != 0 && prev_key != 0), 0);
        if (key != 4'h0) begin
            pulses++;
            last_pe = edge_cnt;
            last_pv = key;
        end
        prev_key = key;
`ifdef KEYCOND_STUCK_DETECT_EN
        chk("stuck", stuck_key, m_stuck);
        if (stuck_key && !prev_stk) rise_e = edge_cnt;
        if (!stuck_key && prev_stk) fall_e = edge_cnt;
        prev_stk = stuck_key;
`endif
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int e0;
        int k;
        model_reset();
        #1;
        reset = 1'b1;
        #1;
        chk("rst_key", key, 0);
        chk("rst_busy", busy, 0);
`ifdef KEYCOND_STUCK_DETECT_EN
        chk("rst_stuck", stuck_key, 0);
`endif
        run(3);
        reset = 1'b0;
        run(5);

        // Clean press of bit1
        keyRaw = 4'b1101;
        e0 = edge_cnt;
        pulses = 0;
        run(100);
        chk("s1_pulses", pulses, 1);
        chk("s1_edge", last_pe, e0 + 53);
        chk("s1_val", last_pv, 4'b0010);
        chk("s1_busy", busy, 1);
        keyRaw = 4'hF;
        run(52);
        chk("s1_busy_hold", busy, 1);
        run(1);
        chk("s1_idle", busy, 0);
        chk("s1_single", pulses, 1);

        // Bounce on bit0
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            keyRaw = (i % 2 == 0) ? 4'b1110 : 4'b1111;
            run(10);
        end
        chk("s2_bounce", pulses, 0);
        keyRaw = 4'b1110;
        e0 = edge_cnt;
        run(60);
        chk("s2_pulses", pulses, 1);
        chk("s2_edge", last_pe, e0 + 53);
        chk("s2_val", last_pv, 4'b0001);
        keyRaw = 4'hF;
        run(60);
        chk("s2_idle", busy, 0);

        // Two keys in the same cycle
        keyRaw = 4'b0110;
        pulses = 0;
        run(100);
        chk("s3_pulses", pulses, 0);
        chk("s3_busy", busy, 1);
        keyRaw = 4'hF;
        run(52);
        chk("s3_busy_hold", busy, 1);
        run(1);
        chk("s3_idle", busy, 0);
        keyRaw = 4'b1110;
        e0 = edge_cnt;
        run(60);
        chk("s3_pulses2", pulses, 1);
        chk("s3_edge", last_pe, e0 + 53);
        chk("s3_val", last_pv, 4'b0001);
        keyRaw = 4'hF;
        run(60);

        // Overlapping presses
        keyRaw = 4'b0111;
        e0 = edge_cnt;
        pulses = 0;
        run(20);
        keyRaw = 4'b0101;
        run(80);
        keyRaw = 4'hF;
        run(70);
        chk("s4_pulses", pulses, 1);
        chk("s4_edge", last_pe, e0 + 53);
        chk("s4_val", last_pv, 4'b1000);
        chk("s4_idle", busy, 0);

        // Reset mid-press, then reset while busy
        keyRaw = 4'b1011;
        pulses = 0;
        run(30);
        reset = 1'b1;
        model_reset();
        #1;
        chk("s5_rst_key", key, 0);
        chk("s5_rst_busy", busy, 0);
        run(3);
        chk("s5_rst_nopulse", pulses, 0);
        reset = 1'b0;
        e0 = edge_cnt;
        run(60);
        chk("s5_pulses", pulses, 1);
        chk("s5_edge", last_pe, e0 + 53);
        chk("s5_val", last_pv, 4'b0100);
        chk("s5_busy", busy, 1);
        reset = 1'b1;
        model_reset();
        #1;
        chk("s5_rst2_busy", busy, 0);
        run(2);
        reset = 1'b0;
        e0 = edge_cnt;
        pulses = 0;
        run(60);
        chk("s5_pulses2", pulses, 1);
        chk("s5_edge2", last_pe, e0 + 53);
        keyRaw = 4'hF;
        run(60);

        // Random holds and chords
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       keyRaw = 4'hF;
                2:       keyRaw = 4'($urandom);
                default: keyRaw = ~(4'b0001 << k);
            endcase
            run($urandom_range(1, 80));
        end
        keyRaw = 4'hF;
        run(120);
        chk("rnd_idle", busy, 0);

`ifdef KEYCOND_STUCK_DETECT_EN
        // Long hold of bit0
        keyRaw = 4'b1110;
        pulses = 0;
        rise_e = -1;
        fall_e = -1;
        run(400);
        chk("s6_pulses", pulses, 1);
        chk("s6_rise", rise_e, last_pe + 200);
        keyRaw = 4'hF;
        e0 = edge_cnt;
        run(60);
        chk("s6_fall", fall_e, e0 + 54);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
